// File: rtl/fft_frame_ctrl_if.sv
// ============================================================
// fft_frame_ctrl_if: sample, fft and bin-stream signals of fft_frame_ctrl.
// sample_right exists only when STEREO_SUM_EN is defined.  Rev 1.0
// ============================================================
`default_nettype none

interface fft_frame_ctrl_if #(
  parameter int WIDTH    = 16,
  parameter int N_2      = 5,
  parameter int IN_WIDTH = 24
);
  logic                  sample_valid;
  logic [IN_WIDTH-1:0]   sample_in;
`ifdef STEREO_SUM_EN
  logic [IN_WIDTH-1:0]   sample_right;
`endif
  logic                  fft_start;
  logic                  fft_load;
  logic [WIDTH-1:0]      fft_rd;
  logic                  fft_done;
  logic [2*WIDTH-1:0]    fft_wd;
  logic                  bin_valid;
  logic [N_2-1:0]        bin_idx;
  logic [2*WIDTH-1:0]    bin_data;
  logic                  frame_done;
  logic                  overrun;
  logic                  busy;

  modport slave (
    input  sample_valid, sample_in, fft_done, fft_wd,
`ifdef STEREO_SUM_EN
    input  sample_right,
`endif
    output fft_start, fft_load, fft_rd, bin_valid, bin_idx, bin_data,
           frame_done, overrun, busy
  );

  modport master (
    output sample_valid, sample_in, fft_done, fft_wd,
`ifdef STEREO_SUM_EN
    output sample_right,
`endif
    input  fft_start, fft_load, fft_rd, bin_valid, bin_idx, bin_data,
           frame_done, overrun, busy
  );
endinterface

`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
// ============================================================
// fft_frame_ctrl: ping-pong frame capture, fft start/load/drain sequencing.
// Optional STEREO_SUM_EN: capture the halved left+right sum.  Rev 1.0
// ============================================================
`default_nettype none

module fft_frame_ctrl #(
  parameter int WIDTH    = 16,
  parameter int N_2      = 5,
  parameter int IN_WIDTH = 24
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  fft_frame_ctrl_if.slave    bus
);
  localparam int             DEPTH = 1 << N_2;
  localparam logic [N_2-1:0] LAST  = N_2'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    LOAD  = 3'd2,
    WAIT  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mem [0:2*DEPTH-1];
  logic [N_2-1:0]     wr_ptr;
  logic [N_2-1:0]     rd_ptr;
  logic [N_2-1:0]     count;
  logic               bank;
  logic               rd_bank;
  logic               frame_rdy;
  logic [WIDTH-1:0]   cap_data;
  logic               wrap;
  logic               enter_load;

`ifdef STEREO_SUM_EN
  logic signed [IN_WIDTH:0] sum;
  logic                     unused_lsbs;
  always_comb begin
    sum = ($signed({bus.sample_in[IN_WIDTH-1], bus.sample_in}) +
           $signed({bus.sample_right[IN_WIDTH-1], bus.sample_right})) >>> 1;
  end
  assign cap_data    = sum[IN_WIDTH -: WIDTH];
  assign unused_lsbs = ^sum[IN_WIDTH-WIDTH:0];
`else
  logic unused_lsbs;
  assign cap_data    = bus.sample_in[IN_WIDTH-1 -: WIDTH];
  assign unused_lsbs = ^bus.sample_in[IN_WIDTH-WIDTH-1:0];
`endif

  assign wrap       = bus.sample_valid && (wr_ptr == LAST);
  assign enter_load = (state == START);
  assign bus.busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (bus.sample_valid) begin
      mem[{bank, wr_ptr}] <= cap_data;
    end
  end

  // A wrap coinciding with entry to LOAD sees the pending frame as already freed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      bank        <= 1'b0;
      frame_rdy   <= 1'b0;
      bus.overrun <= 1'b0;
    end else begin
      if (enter_load) begin
        frame_rdy <= 1'b0;
      end
      if (bus.sample_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (wrap) begin
          if (!frame_rdy || enter_load) begin
            frame_rdy <= 1'b1;
            bank      <= ~bank;
          end else begin
            bus.overrun <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rd_ptr         <= '0;
      rd_bank        <= 1'b0;
      count          <= '0;
      bus.fft_start  <= 1'b0;
      bus.fft_load   <= 1'b0;
      bus.fft_rd     <= '0;
      bus.bin_valid  <= 1'b0;
      bus.bin_idx    <= '0;
      bus.bin_data   <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.fft_start  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.bin_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_rdy) begin
            bus.fft_start <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          rd_bank      <= ~bank;
          bus.fft_rd   <= mem[{~bank, N_2'(0)}];
          rd_ptr       <= N_2'(1);
          bus.fft_load <= 1'b1;
          state        <= LOAD;
        end
        // rd_ptr wraps back to 0 once the last word has been fetched.
        LOAD: begin
          if (rd_ptr == '0) begin
            bus.fft_load <= 1'b0;
            bus.fft_rd   <= '0;
            state        <= WAIT;
          end else begin
            bus.fft_rd <= mem[{rd_bank, rd_ptr}];
            rd_ptr     <= rd_ptr + 1'b1;
          end
        end
        WAIT, DRAIN: begin
          if (bus.bin_valid && (bus.bin_idx == LAST)) begin
            bus.frame_done <= 1'b1;
            count          <= '0;
            state          <= IDLE;
          end else if (bus.fft_done) begin
            bus.bin_valid <= 1'b1;
            bus.bin_data  <= bus.fft_wd;
            bus.bin_idx   <= count;
            count         <= count + 1'b1;
            state         <= DRAIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
// ============================================================
// tb_fft_frame_ctrl: scoreboard bench for fft_frame_ctrl with a frame-level model.
// STEREO_SUM_EN selects the stereo capture model.  Rev 1.0
// ============================================================
`default_nettype none

module tb_fft_frame_ctrl;
  localparam int WIDTH    = 16;
  localparam int N_2      = 5;
  localparam int IN_WIDTH = 24;
  localparam int NPTS     = 1 << N_2;

  typedef logic [N_2+2*WIDTH-1:0] bin_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fft_frame_ctrl_if #(.WIDTH(WIDTH), .N_2(N_2), .IN_WIDTH(IN_WIDTH)) bus ();

  fft_frame_ctrl #(.WIDTH(WIDTH), .N_2(N_2), .IN_WIDTH(IN_WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Frame-level model: a completed frame occupies the single pending slot until
  // the controller starts on it; a frame completing while the slot is full is dropped.
  logic [WIDTH-1:0] cur_q[$];
  logic [WIDTH-1:0] pending_q[$];
  logic [WIDTH-1:0] exp_load_q[$];
  bin_t             exp_bin_q[$];
  bit               pending_v = 0;
  bit               exp_ovr = 0;
  bit               expect_fd = 0;
  int               bins_seen = 0;
  int               load_len = 0;
  int               cyc = 0;
  int               n_start = 0;
  int               start_cyc = 0;
  int               last_wrap_cyc = 0;

  function automatic logic [WIDTH-1:0] captured();
`ifdef STEREO_SUM_EN
    logic signed [IN_WIDTH:0] s;
    s = ($signed({bus.sample_in[IN_WIDTH-1], bus.sample_in}) +
         $signed({bus.sample_right[IN_WIDTH-1], bus.sample_right})) >>> 1;
    return s[IN_WIDTH -: WIDTH];
`else
    return bus.sample_in[IN_WIDTH-1 -: WIDTH];
`endif
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      cur_q.delete();
      pending_q.delete();
      exp_load_q.delete();
      exp_bin_q.delete();
      pending_v = 0;
      exp_ovr   = 0;
      expect_fd = 0;
      bins_seen = 0;
      load_len  = 0;
    end else begin
      check("overrun", bus.overrun, exp_ovr);
      check("frame_done", bus.frame_done, expect_fd);
      if (expect_fd) check("busy_at_done", bus.busy, 0);
      expect_fd = 0;
      if (bus.fft_start) begin
        n_start++;
        start_cyc = cyc;
        check("start_has_frame", pending_v, 1);
        if (pending_v) begin
          exp_load_q = pending_q;
          pending_v  = 0;
        end
      end
      if (bus.fft_load) begin
        load_len++;
        check("load_expected", exp_load_q.size() != 0, 1);
        if (exp_load_q.size() != 0) check("fft_rd", bus.fft_rd, exp_load_q.pop_front());
      end else if (load_len != 0) begin
        check("load_len", load_len, NPTS);
        check("fft_rd_wait", bus.fft_rd, 0);
        load_len = 0;
      end
      if (bus.bin_valid) begin
        check("bin_expected", exp_bin_q.size() != 0, 1);
        if (exp_bin_q.size() != 0) check("bin", {bus.bin_idx, bus.bin_data}, exp_bin_q.pop_front());
        bins_seen++;
        if (bins_seen == NPTS) begin
          expect_fd = 1;
          bins_seen = 0;
        end
      end
      if (bus.sample_valid) begin
        cur_q.push_back(captured());
        if (cur_q.size() == NPTS) begin
          last_wrap_cyc = cyc;
          if (pending_v) begin
            exp_ovr = 1;
          end else begin
            pending_q = cur_q;
            pending_v = 1;
          end
          cur_q.delete();
        end
      end
    end
  end

  task automatic send(input logic [IN_WIDTH-1:0] v, input int gap);
    @(posedge clk); #1;
    bus.sample_valid = 1'b1;
    bus.sample_in    = v;
`ifdef STEREO_SUM_EN
    bus.sample_right = IN_WIDTH'($urandom);
`endif
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_frames(input int nsamp, input bit ramp);
    for (int i = 0; i < nsamp; i++) begin
      send(ramp ? IN_WIDTH'(i << 8) : IN_WIDTH'($urandom), ramp ? 0 : int'($urandom_range(0, 2)));
    end
  endtask

  task automatic wait_load();
    bit seen = 0;
    bit ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (bus.fft_load) seen = 1;
      else if (seen) begin
        ok = 1;
        break;
      end
    end
    check("load_finished", ok, 1);
  endtask

  task automatic wait_fd();
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (bus.frame_done) begin
        ok = 1;
        break;
      end
    end
    check("frame_done_seen", ok, 1);
  endtask

  task automatic drive_bins(input int gap_at, input bit fixed);
    logic [2*WIDTH-1:0] wd;
    for (int k = 0; k < NPTS; k++) begin
      @(posedge clk); #1;
      wd = fixed ? (2*WIDTH)'(k << 16) : (2*WIDTH)'($urandom);
      bus.fft_done = 1'b1;
      bus.fft_wd   = wd;
      exp_bin_q.push_back({N_2'(k), wd});
      if (k == gap_at) begin
        @(posedge clk); #1;
        bus.fft_done = 1'b0;
        bus.fft_wd   = (2*WIDTH)'($urandom);
        @(negedge clk);
        check("gap_last_bin", bus.bin_valid, 1);
        @(negedge clk);
        check("gap_bv_low1", bus.bin_valid, 0);
        @(negedge clk);
        check("gap_bv_low2", bus.bin_valid, 0);
      end
    end
    @(posedge clk); #1;
    bus.fft_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
`ifdef STEREO_SUM_EN
    bus.sample_right = '0;
`endif
    bus.fft_done     = 1'b0;
    bus.fft_wd       = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_fft_start", bus.fft_start, 0);
    check("rst_fft_load", bus.fft_load, 0);
    check("rst_fft_rd", bus.fft_rd, 0);
    check("rst_bin_valid", bus.bin_valid, 0);
    check("rst_bin_idx", bus.bin_idx, 0);
    check("rst_bin_data", bus.bin_data, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_busy", bus.busy, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("no_start_idle", n_start, 0);

    // ramp frame, start latency, WAIT state, fixed bins
    send_frames(NPTS, 1);
    wait_load();
    check("start_latency", start_cyc - last_wrap_cyc, 2);
    check("wait_busy", bus.busy, 1);
    check("wait_load_low", bus.fft_load, 0);
    drive_bins(-1, 1);
    wait_fd();
    @(negedge clk);
    check("idle_busy", bus.busy, 0);

    // random frame, gapped drain
    send_frames(NPTS, 0);
    wait_load();
    drive_bins(10, 0);
    wait_fd();

    // overrun: two more frames arrive while the fft is still busy
    send_frames(NPTS, 0);
    wait_load();
    s0 = n_start;
    send_frames(2*NPTS, 0);
    @(negedge clk);
    check("overrun_set", bus.overrun, 1);
    drive_bins(-1, 0);
    wait_fd();
    wait_load();
    drive_bins(-1, 0);
    wait_fd();
    repeat (100) @(negedge clk);
    check("one_pending_start", n_start - s0, 1);
    check("overrun_sticky", bus.overrun, 1);

    // reset in the middle of LOAD
    send_frames(NPTS, 0);
    begin
      int nl = 0;
      for (int n = 0; n < 3000 && nl < 13; n++) begin
        @(negedge clk);
        if (bus.fft_load) nl++;
      end
      check("reached_load12", nl, 13);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_load", bus.fft_load, 0);
    check("mid_rst_overrun", bus.overrun, 0);
    check("mid_rst_busy", bus.busy, 0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    send_frames(NPTS, 0);
    wait_load();
    check("post_rst_latency", start_cyc - last_wrap_cyc, 2);
    drive_bins(-1, 0);
    wait_fd();
    repeat (5) @(negedge clk);
    check("bins_drained", exp_bin_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

`default_nettype wire
